// File: rtl/mem_sram_responder.sv
// Single-request SRAM responder for the MEM stage Start/Finish handshake.
// Models a programmable access latency in front of a 64-bit word array with byte lanes.
module mem_sram_responder #(
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Read_Start,
    input  logic [63:0] Read_ADDR,
    output logic [63:0] Read_Data,
    output logic        Finish_Read,
    input  logic        Write_Start,
    input  logic [63:0] Write_ADDR,
    input  logic [63:0] Write_Data,
    input  logic [7:0]  Write_Strb,
    output logic        Finish_Write,
    output logic        Resp_Err,
    output logic [1:0]  dbg_state_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Handshake: Start is a level held by the initiator until it sees the one-cycle
    // Finish of that op; the responder waits in HOLD for the Start to drop.
    typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               op_wr_q, op_wr_d;
    logic [63:0]        addr_q, addr_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [7:0]         strb_q, strb_d;
    logic [63:0]        rdata_q, rdata_d;
    logic               fin_rd_q, fin_rd_d;
    logic               fin_wr_q, fin_wr_d;
    logic               err_q, err_d;
    logic [63:0]        mem_q [DEPTH];

    logic [63:0]            offset;
    logic                   in_range;
    logic [DEPTH_LOG2-1:0]  idx;
    logic [2:0]             lane;
    logic [63:0]            word;
    logic [63:0]            data_sh;
    logic [7:0]             lane_mask;
    logic [63:0]            merged;
    logic                   mem_we;

    assign offset    = addr_q - BASE_ADDR;
    assign in_range  = (offset >> (DEPTH_LOG2 + 3)) == 64'd0;
    assign idx       = offset[DEPTH_LOG2+2:3];
    assign lane      = addr_q[2:0];
    assign word      = mem_q[idx];
    assign data_sh   = wdata_q << {lane, 3'b000};
    // Strobe bits pushed past byte 7 fall off the 8-bit result.
    assign lane_mask = strb_q << lane;

    always_comb begin
        merged = word;
        for (int i = 0; i < 8; i++) begin
            if (lane_mask[i]) merged[8*i +: 8] = data_sh[8*i +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_wr_d  = op_wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        rdata_d  = rdata_q;
        fin_rd_d = 1'b0;
        fin_wr_d = 1'b0;
        err_d    = err_q;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Write_Start) begin
                    op_wr_d = 1'b1;
                    addr_d  = Write_ADDR;
                    wdata_d = Write_Data;
                    strb_d  = Write_Strb;
                    cnt_d   = 4'(LATENCY);
                    state_d = WAIT;
                end else if (Read_Start) begin
                    op_wr_d = 1'b0;
                    addr_d  = Read_ADDR;
                    cnt_d   = 4'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    err_d   = !in_range;
                    if (op_wr_q) begin
                        fin_wr_d = 1'b1;
                        mem_we   = in_range;
                    end else begin
                        fin_rd_d = 1'b1;
                        rdata_d  = in_range ? (word >> {lane, 3'b000}) : 64'd0;
                    end
                end
            end
            RESP: state_d = HOLD;
            HOLD: begin
                if (op_wr_q ? !Write_Start : !Read_Start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            op_wr_q  <= 1'b0;
            addr_q   <= 64'd0;
            wdata_q  <= 64'd0;
            strb_q   <= 8'd0;
            rdata_q  <= 64'd0;
            fin_rd_q <= 1'b0;
            fin_wr_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            rdata_q  <= rdata_d;
            fin_rd_q <= fin_rd_d;
            fin_wr_q <= fin_wr_d;
            err_q    <= err_d;
        end
    end

    // Array is not reset; a reset edge suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem_q[idx] <= merged;
    end

    assign Read_Data    = rdata_q;
    assign Finish_Read  = fin_rd_q;
    assign Finish_Write = fin_wr_q;
    assign Resp_Err     = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_sram_responder.sv
// Self-checking bench for mem_sram_responder against a byte-addressed memory model.
module tb_mem_sram_responder;
  localparam int              LAT  = 2;
  localparam longint unsigned BASE = 64'h8000_0000;
  localparam longint unsigned SPAN = 64'd32768;

  logic        clk = 1'b0;
  logic        rst;
  logic        Read_Start, Write_Start;
  logic [63:0] Read_ADDR, Write_ADDR, Write_Data, Read_Data;
  logic [7:0]  Write_Strb;
  logic        Finish_Read, Finish_Write, Resp_Err;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  mb [longint unsigned];
  logic [63:0] exp_q [$];
  logic [63:0] last_rd;

  mem_sram_responder #(.DEPTH_LOG2(12), .LATENCY(LAT), .BASE_ADDR(64'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .Read_Start(Read_Start), .Read_ADDR(Read_ADDR), .Read_Data(Read_Data),
    .Finish_Read(Finish_Read),
    .Write_Start(Write_Start), .Write_ADDR(Write_ADDR), .Write_Data(Write_Data),
    .Write_Strb(Write_Strb), .Finish_Write(Finish_Write),
    .Resp_Err(Resp_Err), .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: byte-addressed memory
  function automatic bit in_range(input longint unsigned a);
    return (a - BASE) < SPAN;
  endfunction

  function automatic logic [63:0] model_read(input longint unsigned a);
    logic [63:0] r;
    r = 64'd0;
    if (!in_range(a)) return r;
    for (int i = 0; i < 8 - int'(a % 8); i++)
      r[8*i +: 8] = mb.exists(a + i) ? mb[a + i] : 8'h00;
    return r;
  endfunction

  task automatic model_write(input longint unsigned a, input logic [63:0] d, input logic [7:0] s);
    if (!in_range(a)) return;
    for (int i = 0; i < 8; i++)
      if (s[i] && (int'(a % 8) + i) < 8) mb[a + i] = d[8*i +: 8];
  endtask

  // driver tasks (entered and left at a negedge)
  task automatic wait_fin(output int n, output logic fr, output logic fw);
    n = 0;
    do begin
      @(posedge clk); @(negedge clk);
      n++;
    end while (!(Finish_Read || Finish_Write) && n < 40);
    fr = Finish_Read;
    fw = Finish_Write;
    check("finish_exclusive", 64'(fr & fw), 64'd0);
  endtask

  task automatic hold_and_release(input int hold_extra);
    for (int i = 0; i <= hold_extra; i++) begin
      @(posedge clk); @(negedge clk);
      check("pulse_len", {62'd0, Finish_Read, Finish_Write}, 64'd0);
    end
    Read_Start  = 1'b0;
    Write_Start = 1'b0;
    @(posedge clk); @(negedge clk);
    check("back_idle", 64'(dbg_state), 64'd0);
  endtask

  task automatic txn(input bit wr, input logic [63:0] addr, input logic [63:0] data,
                     input logic [7:0] strb, input int hold_extra);
    int n;
    logic fr, fw;
    logic [63:0] e;
    if (wr) begin
      Write_Start = 1'b1; Write_ADDR = addr; Write_Data = data; Write_Strb = strb;
    end else begin
      Read_Start = 1'b1; Read_ADDR = addr;
      exp_q.push_back(model_read(addr));
    end
    wait_fin(n, fr, fw);
    check("latency", 64'(n), 64'(LAT + 2));
    check("fin_rd", 64'(fr), 64'(!wr));
    check("fin_wr", 64'(fw), 64'(wr));
    check("resp_err", 64'(Resp_Err), 64'(!in_range(addr)));
    if (wr) begin
      model_write(addr, data, strb);
      check("rdata_stable", Read_Data, last_rd);
    end else begin
      e = exp_q.pop_front();
      check("rdata", Read_Data, e);
      last_rd = e;
    end
    hold_and_release(hold_extra);
  endtask

  initial begin : main
    int n;
    logic fr, fw;
    logic [63:0] a, d;

    // reset
    rst = 1'b1; Read_Start = 1'b0; Write_Start = 1'b0;
    Read_ADDR = '0; Write_ADDR = '0; Write_Data = '0; Write_Strb = '0;
    last_rd = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", Read_Data, 64'd0);
    check("rst_fin", {62'd0, Finish_Read, Finish_Write}, 64'd0);
    check("rst_err", 64'(Resp_Err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    // initialise the words the bench reads back
    for (int w = 0; w < 8; w++) txn(1'b1, BASE + 64'(8 * w), 64'd0, 8'hFF, 0);
    txn(1'b1, BASE + 64'h7FF8, {$urandom, $urandom}, 8'hFF, 0);

    // store/load round trip
    txn(1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 0);
    txn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0);
    check("roundtrip_const", Read_Data, 64'h1122334455667788);

    // sub-word write and read
    txn(1'b1, 64'h8000_0010, 64'd0, 8'hFF, 0);
    txn(1'b1, 64'h8000_0013, 64'hAB, 8'h01, 0);
    txn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0);
    check("subword_word", Read_Data, 64'h0000_0000_AB00_0000);
    txn(1'b0, 64'h8000_0013, 64'd0, 8'h00, 0);
    check("subword_lane", Read_Data, 64'h0000_0000_0000_00AB);

    // lane overflow
    txn(1'b1, 64'h8000_0006, 64'hDDCCBBAA, 8'h0F, 0);
    txn(1'b0, 64'h8000_0000, 64'd0, 8'h00, 0);
    check("overflow_word", Read_Data, 64'hBBAA_0000_0000_0000);
    txn(1'b0, 64'h8000_0008, 64'd0, 8'h00, 0);

    // out of range and in-range boundary
    txn(1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 0);
    txn(1'b1, 64'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    txn(1'b0, 64'h8000_0000, 64'd0, 8'h00, 0);
    txn(1'b0, BASE + 64'h7FF8, 64'd0, 8'h00, 0);

    // held read start: only one pulse
    txn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 5);

    // simultaneous starts: write first, then read sees written data
    d = {$urandom, $urandom};
    Write_Start = 1'b1; Write_ADDR = 64'h8000_0020; Write_Data = d; Write_Strb = 8'hFF;
    Read_Start  = 1'b1; Read_ADDR  = 64'h8000_0020;
    wait_fin(n, fr, fw);
    check("prio_lat", 64'(n), 64'(LAT + 2));
    check("prio_wr_first", {62'd0, fr, fw}, 64'd1);
    model_write(64'h8000_0020, d, 8'hFF);
    @(posedge clk); @(negedge clk);
    check("prio_pulse", {62'd0, Finish_Read, Finish_Write}, 64'd0);
    Write_Start = 1'b0;
    exp_q.push_back(model_read(64'h8000_0020));
    wait_fin(n, fr, fw);
    check("prio_rd_lat", 64'(n), 64'(LAT + 3));
    check("prio_rd_fin", {62'd0, fr, fw}, 64'd2);
    last_rd = exp_q.pop_front();
    check("prio_rd_data", Read_Data, last_rd);
    check("prio_rd_const", Read_Data, d);
    hold_and_release(0);

    // reset during WAIT of a write
    Write_Start = 1'b1; Write_ADDR = 64'h8000_0018; Write_Data = 64'hDEAD_BEEF_0BAD_F00D;
    Write_Strb = 8'hFF;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_rdata", Read_Data, 64'd0);
    check("midrst_fin", {62'd0, Finish_Read, Finish_Write}, 64'd0);
    check("midrst_err", 64'(Resp_Err), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    Write_Start = 1'b0; rst = 1'b0; last_rd = 64'd0;
    @(posedge clk); @(negedge clk);
    txn(1'b0, 64'h8000_0018, 64'd0, 8'h00, 0);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 7))
        0:       a = BASE + 64'h7FF8 + 64'($urandom_range(0, 7));
        1:       a = ($urandom_range(0, 1) == 0) ? BASE - 64'($urandom_range(1, 8))
                                                 : BASE + SPAN + 64'($urandom_range(0, 7));
        default: a = BASE + 64'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 1) == 1)
        txn(1'b1, a, {$urandom, $urandom}, 8'($urandom_range(0, 255)), $urandom_range(0, 2));
      else
        txn(1'b0, a, 64'd0, 8'h00, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_sram_responder.md
# mem_sram_responder

Memory-side responder for the MEM stage's Start/Finish load/store handshake. It accepts one read or write request at a time, waits a programmable number of cycles to model memory latency, and then accesses an internal 64-bit-wide SRAM array. It returns a one-cycle Finish pulse with byte-aligned read data and an error flag. It sits between the MEM stage and the simulation memory, replacing DPI-C pmem access in the NPC core.

## Interface

Parameters:
- DEPTH_LOG2, 12: array depth is 2^DEPTH_LOG2 64-bit words.
- LATENCY, 2: extra wait cycles per request, legal range 0..15.
- BASE_ADDR, 64'h8000_0000: byte address of word 0.

Ports:
- clk, input, 1: the single clock; all logic on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- Read_Start, input, 1: read request level; held by the initiator until after Finish_Read.
- Read_ADDR, input, 64: read byte address.
- Read_Data, output, 64: read result; stable from Finish_Read until the next read completes.
- Finish_Read, output, 1: read-done pulse, exactly one cycle.
- Write_Start, input, 1: write request level.
- Write_ADDR, input, 64: write byte address.
- Write_Data, input, 64: store data, LSB-aligned.
- Write_Strb, input, 8: byte enables, LSB-aligned (for example 8'h0F selects 4 bytes).
- Finish_Write, output, 1: write-done pulse, exactly one cycle.
- Resp_Err, output, 1: address out of range; valid while either Finish is high and held until the next Finish.

## Operation

- States: IDLE, WAIT, RESP, HOLD. All outputs are registered.
- **IDLE**
  - Write_Start high: accept a write. Write_Start has priority when both Start inputs are high.
  - Else Read_Start high: accept a read.
  - On accept, latch op, address, data and strobe. Load the counter with LATENCY and go to WAIT.
- **WAIT**
  - counter != 0: decrement.
  - counter == 0: perform the access and go to RESP.
- **Access**
  - offset = latched ADDR - BASE_ADDR (64-bit, wrap allowed).
  - The access is in range when offset[63:DEPTH_LOG2+3] == 0.
  - The word index is offset[DEPTH_LOG2+2:3]. The byte lane is b = ADDR[2:0].
  - Read, in range: Read_Data = word >> (8*b), zero-filled. Resp_Err = 0.
  - Write, in range: bytes in (Write_Strb << b)[7:0] take the matching bytes of (Write_Data << 8*b). Strobe bits shifted past lane 7 are dropped. Resp_Err = 0.
  - Out of range: a read returns Read_Data = 0. A write leaves the array unchanged. Resp_Err = 1.
- **RESP**: Finish of the served op is high for this one cycle. Always go to HOLD.
- **HOLD**: stay until the served op's Start is sampled low, then go to IDLE. This prevents re-triggering, because the initiator drops Start one cycle after seeing Finish.
- A Start change during WAIT is ignored. The latched request completes.
- The other op's Start held high during a transaction is served from IDLE after HOLD exits. Write-then-read ordering is therefore preserved.

## Timing

- Reset:
  - State IDLE and counter 0.
  - Finish_Read = 0, Finish_Write = 0, Read_Data = 0, Resp_Err = 0.
  - Array contents are not cleared.
  - Reset mid-transaction aborts it with no Finish and no array write if the write had not yet reached the WAIT→RESP edge.
- Latency: Start is first sampled high in IDLE at edge E. Finish is high in the cycle after edge E+LATENCY+1.
  - LATENCY=0: Finish follows the accept edge by one cycle.
- The array write commits on the same edge that raises Finish_Write. A read issued after that sees the new data.
- Minimum back-to-back spacing is LATENCY+4 cycles when Start is dropped immediately after Finish.
- Finish_Read and Finish_Write are never high together and never high for two consecutive cycles.

## Test plan

1. **Store/load round trip.** LATENCY=2. Write 0x8000_0010, data 0x1122334455667788, strb 0xFF, then read 0x8000_0010.
   - Finish_Write is high 4 cycles after the Start edge.
   - Read_Data = 0x1122334455667788 and Resp_Err = 0.
2. **Sub-word write and read.** Write 0x8000_0013, data 0xAB, strb 0x01 into a word holding 0.
   - Read 0x8000_0010 returns 0x00000000_AB000000.
   - Read 0x8000_0013 returns 0x0000000000_0000AB at bits 7:0, zero-filled above.
3. **Lane overflow.** Write 0x8000_0006, strb 0x0F, data 0xDDCCBBAA.
   - Only bytes 6 and 7 change, to 0xBB and 0xAA (AA at byte 6, BB at byte 7).
   - The next word is untouched.
4. **Out of range.** Read 0x7FFF_FFF8 and write 0x8000_8000 (DEPTH_LOG2=12).
   - Resp_Err = 1 and Read_Data = 0.
   - A subsequent read of 0x8000_0000 is unchanged.
5. **Held Start and priority.**
   - Hold Read_Start high 5 cycles past Finish_Read: exactly one Finish_Read pulse.
   - Raise Read_Start and Write_Start together: the write completes first, then the read returns the written data.
6. **Reset mid-operation.** Assert rst during WAIT of a write.
   - Next cycle: all outputs 0, state IDLE.
   - The target word is unchanged.
   - A new read after reset completes normally.
